ysyx_23060240_fetch_ctrl: RTL and testbench
===========================================

YSYX_23060240_FETCH_CTRL -- requirements
Module: ysyx_23060240_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: the first fetch address after reset SHALL be RESET_PC.
REQ-002 Port clk, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset SHALL be asynchronous and active-low.
REQ-004 Port imem_req_valid, output, 1: instruction memory request valid.
REQ-005 Port imem_req_addr, output, 32: fetch address.
REQ-006 Port imem_req_ready, input, 1: memory accepts the request.
REQ-007 Port imem_rsp_valid, input, 1: response data valid.
REQ-008 Port imem_rsp_data, input, 32: fetched instruction word.
REQ-009 Port imem_rsp_err, input, 1: bus error on the response.
REQ-010 Port imem_rsp_ready, output, 1: the block accepts the response.
REQ-011 Port inst_valid, output, 1: instruction offered to decode.
REQ-012 Port inst, output, 32: instruction word.
REQ-013 Port pc, output, 32: address of inst.
REQ-014 Port inst_ready, input, 1: decode/execute consumes inst.
REQ-015 Port redirect_en, input, 1: the consumed instruction changes control flow (jump, branch, ecall, mret).
REQ-016 Port redirect_pc, input, 32: next-PC target.
REQ-017 Port fetch_fault, output, 1: sticky fetch fault flag.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, HOLD and FAULT.
- IDLE→REQ unconditionally after one cycle.
- REQ→WAIT on imem_req_valid&&imem_req_ready.
- WAIT→HOLD on imem_rsp_valid&&imem_rsp_ready.
- HOLD→REQ on inst_valid&&inst_ready.
REQ-019 In REQ the block SHALL drive imem_req_valid=1 and imem_req_addr=pc, holding both stable until the handshake completes.
REQ-020 imem_rsp_ready SHALL be 1 only in WAIT; rsp_valid in any other state SHALL be ignored, including the cycle of the request handshake.
REQ-021 On the response handshake, inst SHALL capture imem_rsp_data and inst_valid SHALL rise in the next cycle.
REQ-022 In HOLD, inst_valid, inst and pc SHALL stay stable until inst_ready=1.
REQ-023 On the inst handshake:
- pc SHALL become redirect_pc when redirect_en=1;
- otherwise pc SHALL become pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
REQ-024 redirect_en SHALL be sampled only on the inst handshake; all other values SHALL be ignored.
REQ-025 inst_ready outside HOLD SHALL have no effect.
REQ-026 Minimum latency SHALL be: request handshake in cycle N, response in N+1, inst_valid in N+2. Peak throughput SHALL be one instruction per 3 cycles.
REQ-027 inst SHALL remain the last captured word when inst_valid=0.

Reset
REQ-028 While rst=0, outputs SHALL be: pc=RESET_PC, state=IDLE, inst_valid=0, inst=32'h0, imem_req_valid=0, imem_req_addr=RESET_PC, imem_rsp_ready=0, fetch_fault=0.
REQ-029 Reset asserted mid-transaction SHALL discard the outstanding request/response immediately; a stale imem_rsp_valid after release SHALL be ignored per REQ-020.

Configuration
REQ-030 Macro YSYX_23060240_FETCH_FAULT_EN defined:
- redirect_pc[1:0]!=0 on the handshake, or imem_rsp_err=1 on the response, SHALL set fetch_fault=1 and enter FAULT.
- FAULT SHALL drive imem_req_valid=0 and inst_valid=0 and exit only by reset.
- pc SHALL hold the faulting target/address.
REQ-031 Macro undefined:
- no FAULT state; fetch_fault SHALL be tied 0.
- redirect_pc[1:0] SHALL be forced to 2'b00.
- imem_rsp_err SHALL be ignored.

Structure
REQ-032 The shared package ysyx_23060240_pkg SHALL hold the FSM state enum, the RESET_PC default constant and the PC increment constant 32'h4.
REQ-033 The block SHALL be one module with no sub-module; the FSM and PC register SHALL be separate always blocks.

Verification
REQ-034 Release reset with zero-wait memory: first imem_req_addr=32'h8000_0000, inst_valid in cycle 3, pc sequence 8000_0000, 8000_0004, 8000_0008.
REQ-035 Hold imem_req_ready=0 for 4 cycles: imem_req_valid stays 1 with a stable address and no extra request is issued.
REQ-036 Hold inst_ready=0 for 5 cycles in HOLD: inst and pc are unchanged and no new request is issued.
REQ-037 redirect_en=1, redirect_pc=32'h8000_0100 on the handshake: next imem_req_addr=32'h8000_0100. Also pulse redirect_en while in WAIT: it is ignored.
REQ-038 pc=32'hFFFF_FFFC consumed without redirect: next request address is 32'h0.
REQ-039 With the macro defined:
- redirect_pc=32'h8000_0102 → fetch_fault=1 and no further requests.
- imem_rsp_err=1 → fetch_fault=1.
- Without the macro, the same 32'h8000_0102 stimulus → request at 32'h8000_0100.

Source files
------------

// File: rtl/ysyx_23060240_pkg.sv
// Shared types and constants for the ysyx_23060240 fetch path.
// The FAULT state exists only when YSYX_23060240_FETCH_FAULT_EN is defined.
package ysyx_23060240_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] PC_INC           = 32'h4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
`ifdef YSYX_23060240_FETCH_FAULT_EN
        , FAULT
`endif
    } fetch_state_e;

endpackage

// File: rtl/ysyx_23060240_fetch_ctrl.sv
// Single-outstanding instruction fetch controller: request, response, hold-for-decode.
// Optional fault trapping (misaligned redirect, bus error) under YSYX_23060240_FETCH_FAULT_EN.
import ysyx_23060240_pkg::*;

module ysyx_23060240_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        imem_rsp_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        inst_ready,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    fetch_state_e state;
    logic         req_hs;
    logic         rsp_hs;
    logic         inst_hs;
    logic [31:0]  redirect_tgt;

    assign req_hs        = (state == REQ)  && imem_req_valid && imem_req_ready;
    assign rsp_hs        = (state == WAIT) && imem_rsp_valid && imem_rsp_ready;
    assign inst_hs       = (state == HOLD) && inst_valid && inst_ready;
    assign imem_req_addr = pc;

`ifdef YSYX_23060240_FETCH_FAULT_EN
    logic fault_q;
    logic tgt_misaligned;

    assign redirect_tgt   = redirect_pc;
    assign tgt_misaligned = redirect_en && (redirect_pc[1:0] != 2'b00);
    assign fetch_fault    = fault_q;
`else
    logic unused_fault_inputs;

    // Without fault trapping, targets are forced word-aligned and bus errors are dropped.
    assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
    assign fetch_fault         = 1'b0;
    assign unused_fault_inputs = ^{imem_rsp_err, redirect_pc[1:0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            imem_req_valid <= 1'b0;
            imem_rsp_ready <= 1'b0;
            inst_valid     <= 1'b0;
`ifdef YSYX_23060240_FETCH_FAULT_EN
            fault_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: begin
                    if (req_hs) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                        imem_rsp_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (rsp_hs) begin
                        imem_rsp_ready <= 1'b0;
`ifdef YSYX_23060240_FETCH_FAULT_EN
                        if (imem_rsp_err) begin
                            state   <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state      <= HOLD;
                            inst_valid <= 1'b1;
                        end
`else
                        state      <= HOLD;
                        inst_valid <= 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (inst_hs) begin
                        inst_valid <= 1'b0;
`ifdef YSYX_23060240_FETCH_FAULT_EN
                        if (tgt_misaligned) begin
                            state   <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
`else
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
`endif
                    end
                end
`ifdef YSYX_23060240_FETCH_FAULT_EN
                // Terminal: only reset leaves FAULT.
                FAULT: begin
                    imem_req_valid <= 1'b0;
                    imem_rsp_ready <= 1'b0;
                    inst_valid     <= 1'b0;
                end
`endif
                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                    imem_rsp_ready <= 1'b0;
                    inst_valid     <= 1'b0;
                end
            endcase
        end
    end

    // PC advances only when decode consumes the held instruction; a fault keeps the offending address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= RESET_PC;
            inst <= 32'h0;
        end else begin
            if (inst_hs) begin
                pc <= redirect_en ? redirect_tgt : pc + PC_INC;
            end
            if (rsp_hs) begin
                inst <= imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_fetch_ctrl.sv
// Directed self-checking bench for ysyx_23060240_fetch_ctrl (default build and YSYX_23060240_FETCH_FAULT_EN build).
module tb_ysyx_23060240_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        imem_rsp_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_ready;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    ysyx_23060240_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .imem_rsp_ready (imem_rsp_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .pc             (pc),
        .inst_ready     (inst_ready),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT sampled in REQ; returns sampled in HOLD with inst_ready low.
    task automatic fetch_one(input string tag, input logic [31:0] exp_pc, input logic [31:0] word);
        check({tag, ".req_valid"}, {31'b0, imem_req_valid}, 32'd1);
        check({tag, ".req_addr"}, imem_req_addr, exp_pc);
        check({tag, ".rsp_ready_in_req"}, {31'b0, imem_rsp_ready}, 32'd0);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        inst_ready     = 1'b1;
        step();
        check({tag, ".rsp_ready"}, {31'b0, imem_rsp_ready}, 32'd1);
        check({tag, ".req_valid_wait"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, ".inst_valid_wait"}, {31'b0, inst_valid}, 32'd0);
        imem_req_ready = 1'b0;
        step();
        check({tag, ".inst_valid"}, {31'b0, inst_valid}, 32'd1);
        check({tag, ".inst"}, inst, word);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".rsp_ready_hold"}, {31'b0, imem_rsp_ready}, 32'd0);
        inst_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        redirect_en    = 1'b0;
        redirect_pc    = 32'h0;

        // Reset values
        step();
        step();
        check("rst.pc", pc, 32'h8000_0000);
        check("rst.req_addr", imem_req_addr, 32'h8000_0000);
        check("rst.req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst.rsp_ready", {31'b0, imem_rsp_ready}, 32'd0);
        check("rst.inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst.inst", inst, 32'h0);
        check("rst.fault", {31'b0, fetch_fault}, 32'd0);

        // Release: IDLE for one cycle, then three back-to-back zero-wait fetches
        rst = 1'b1;
        check("idle.req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        fetch_one("f0", 32'h8000_0000, 32'h0000_0013);
        inst_ready = 1'b1;
        step();
        fetch_one("f1", 32'h8000_0004, 32'h0010_0093);
        inst_ready = 1'b1;
        step();
        fetch_one("f2", 32'h8000_0008, 32'h0020_0113);
        inst_ready = 1'b1;
        step();

        // Memory stalls the request for 4 cycles
        imem_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall.req_valid", {31'b0, imem_req_valid}, 32'd1);
            check("stall.req_addr", imem_req_addr, 32'h8000_000C);
            check("stall.rsp_ready", {31'b0, imem_rsp_ready}, 32'd0);
        end
        fetch_one("f3", 32'h8000_000C, 32'hDEAD_BEEF);

        // Decode stalls for 5 cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold.inst_valid", {31'b0, inst_valid}, 32'd1);
            check("hold.inst", inst, 32'hDEAD_BEEF);
            check("hold.pc", pc, 32'h8000_000C);
            check("hold.req_valid", {31'b0, imem_req_valid}, 32'd0);
        end

        // Redirect on consume; a redirect pulse during WAIT is ignored
        inst_ready  = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h8000_0100;
        step();
        redirect_en = 1'b0;
        inst_ready  = 1'b0;
        check("redir.req_addr", imem_req_addr, 32'h8000_0100);
        check("redir.inst_keep", inst, 32'hDEAD_BEEF);
        check("redir.inst_valid", {31'b0, inst_valid}, 32'd0);
        imem_req_ready = 1'b1;
        imem_rsp_data  = 32'h1111_2222;
        step();
        imem_req_ready = 1'b0;
        redirect_en    = 1'b1;
        redirect_pc    = 32'h1234_5670;
        step();
        redirect_en = 1'b0;
        check("wait_redir.pc", pc, 32'h8000_0100);
        check("wait_redir.inst", inst, 32'h1111_2222);
        inst_ready = 1'b1;
        step();
        check("wait_redir.next_addr", imem_req_addr, 32'h8000_0104);

        // Fetch at the top of the address space wraps to zero
        fetch_one("f4", 32'h8000_0104, 32'h3333_4444);
        inst_ready  = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_en = 1'b0;
        fetch_one("f5", 32'hFFFF_FFFC, 32'h5555_6666);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("wrap.req_addr", imem_req_addr, 32'h0000_0000);

        // Reset in WAIT discards the transaction; stale rsp_valid is ignored afterwards
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("midrst.in_wait", {31'b0, imem_rsp_ready}, 32'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        rst = 1'b0;
        #1;
        check("midrst.rsp_ready", {31'b0, imem_rsp_ready}, 32'd0);
        check("midrst.pc", pc, 32'h8000_0000);
        check("midrst.inst", inst, 32'h0);
        step();
        rst = 1'b1;
        step();
        check("postrst.inst_valid", {31'b0, inst_valid}, 32'd0);
        check("postrst.inst", inst, 32'h0);
        fetch_one("f6", 32'h8000_0000, 32'h7777_8888);

        // Misaligned redirect target
        inst_ready  = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h8000_0102;
        step();
        redirect_en = 1'b0;
        inst_ready  = 1'b0;
`ifdef YSYX_23060240_FETCH_FAULT_EN
        check("misalign.fault", {31'b0, fetch_fault}, 32'd1);
        check("misalign.pc", pc, 32'h8000_0102);
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'b1;
            step();
            check("misalign.req_valid", {31'b0, imem_req_valid}, 32'd0);
            check("misalign.inst_valid", {31'b0, inst_valid}, 32'd0);
        end
        imem_req_ready = 1'b0;
        rst = 1'b0;
        step();
        check("fault_rst.fault", {31'b0, fetch_fault}, 32'd0);
        rst = 1'b1;
        step();
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        step();
        imem_rsp_err   = 1'b0;
        check("rsperr.fault", {31'b0, fetch_fault}, 32'd1);
        check("rsperr.inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rsperr.pc", pc, 32'h8000_0000);
        step();
        check("rsperr.req_valid", {31'b0, imem_req_valid}, 32'd0);
`else
        check("misalign.req_addr", imem_req_addr, 32'h8000_0100);
        check("misalign.fault", {31'b0, fetch_fault}, 32'd0);
        check("misalign.req_valid", {31'b0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'h9999_AAAA;
        step();
        imem_rsp_err   = 1'b0;
        check("rsperr.fault", {31'b0, fetch_fault}, 32'd0);
        check("rsperr.inst_valid", {31'b0, inst_valid}, 32'd1);
        check("rsperr.inst", inst, 32'h9999_AAAA);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
